operand_stack: RTL and testbench
================================

// Module: operand_stack
// PURPOSE
//  LIFO operand stack for the multicycle stack CPU; sits directly downstream of the controller.
//  Consumes the controller's tos/pop/push/MtoS strobes.
//  Selects push data from memory read data or ALU result.
//  Presents a registered top-of-stack word that the datapath A/B registers load one state later.
// PARAMETERS
//  WIDTH  8   data word width in bits
//  DEPTH  16  stack entries; power of two, >= 2; AW = $clog2(DEPTH)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  push       in   1        write selected data at sp, sp+1
//  pop        in   1        read entry sp-1 to top_out, sp-1
//  tos        in   1        read entry sp-1 to top_out, sp unchanged
//  MtoS       in   1        push data select: 1 = mem_data, 0 = alu_res
//  mem_data   in   WIDTH    memory read data
//  alu_res    in   WIDTH    ALU result
//  top_out    out  WIDTH    registered word read by the last pop/tos
//  sp         out  AW+1     entry count, 0..DEPTH
//  empty      out  1        sp == 0 (combinational from sp)
//  full       out  1        sp == DEPTH (combinational from sp)
//  overflow   out  1        sticky: push attempted while full
//  underflow  out  1        sticky: pop/tos attempted while empty
// BEHAVIOUR
//  Reset (async, any time, incl. mid-sequence):
//   - sp=0, top_out=0, overflow=0, underflow=0 -> empty=1, full=0
//   - storage contents undefined, never read before being written
//  Push data: din = MtoS ? mem_data : alu_res, sampled at the push edge.
//  Priority per edge (exactly one row applies):
//   1 push&pop, !empty: top_out<=mem[sp-1]; mem[sp-1]<=din; sp unchanged (replace top)
//   2 push&pop, empty: treated as row 3
//   3 push (no pop), !full: mem[sp]<=din; sp<=sp+1; top_out unchanged
//   4 push (no pop), full: ignored; sp/mem/top_out unchanged
//   5 pop, !empty: top_out<=mem[sp-1]; sp<=sp-1
//   6 pop, empty: ignored; top_out, sp unchanged
//   7 tos only, !empty: top_out<=mem[sp-1]; sp unchanged
//   8 tos only, empty: ignored; top_out unchanged
//   9 none: hold
//  tos is ignored whenever push or pop is asserted.
//  Latency: top_out valid the cycle after the pop/tos edge (matches the pop->loadA, pop->loadB state order).
//  A pop following a push reads the pushed word (no bypass needed; write lands first).
//  sp arithmetic is unsigned AW+1 bits and never wraps; bounds are enforced by rows 4/6/8.
// CONFIGURATION
//  STACK_ERR_CHECK_EN defined:
//   - overflow set by row 4; underflow set by rows 6/8
//   - both sticky until rst
//  Not defined:
//   - overflow/underflow ports remain, tied to 0
//   - rows 4/6/8 still ignore the operation
// TESTING
//  T1 rst mid-run after 3 pushes -> sp=0, empty=1, top_out=0, flags 0 immediately (async).
//  T2 push MtoS=1 mem_data=0x11, push MtoS=0 alu_res=0x22, pop, pop -> top_out 0x22 then 0x11; sp 2,1,0; empty=1 at end.
//  T3 push 0x05; tos; tos -> top_out=0x05 both cycles, sp stays 1.
//  T4 fill DEPTH=16 with 0..15, push 0xAA -> sp=16, full=1, mem unchanged; overflow=1 iff STACK_ERR_CHECK_EN; pop -> 0x0F.
//  T5 empty: pop, then tos -> top_out, sp unchanged; underflow=1 iff STACK_ERR_CHECK_EN, stays 1 until rst.
//  T6 sp=2 (0x01, 0x02), push&pop din=0x33 -> top_out=0x02, sp=2; pop -> 0x33.

Source files
------------

// File: rtl/operand_stack.sv
`default_nettype none
// ============================================================================
// Module   : operand_stack
// Brief    : LIFO operand stack for the multicycle stack CPU. Takes the
//            controller's push/pop/tos/MtoS strobes and pushes memory read
//            data or the ALU result. The top-of-stack word is registered, so
//            the datapath A/B registers load it one state later.
// Ports    : clk       - clock, rising edge
//            rst       - reset, asynchronous, active-high
//            push      - write selected data at sp, sp <= sp+1
//            pop       - read entry sp-1 into top_out, sp <= sp-1
//            tos       - read entry sp-1 into top_out, sp unchanged
//            MtoS      - push data select: 1 = mem_data, 0 = alu_res
//            mem_data  - memory read data
//            alu_res   - ALU result
//            top_out   - registered word read by the last pop/tos
//            sp        - entry count, 0..DEPTH
//            empty     - sp == 0
//            full      - sp == DEPTH
//            overflow  - sticky: push attempted while full
//            underflow - sticky: pop/tos attempted while empty
// Config   : STACK_ERR_CHECK_EN - when defined, overflow/underflow are
//            sticky error flags; otherwise both are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    tos,
    input  logic                    MtoS,
    input  logic [WIDTH-1:0]        mem_data,
    input  logic [WIDTH-1:0]        alu_res,
    output logic [WIDTH-1:0]        top_out,
    output logic [$clog2(DEPTH):0]  sp,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_ONE   = (c_AW+1)'(1);
    localparam logic [c_AW:0]   c_DEPTH = (c_AW+1)'(DEPTH);

    // Storage has no reset: an entry is only ever read below sp, and every
    // entry below sp has been written since the last reset.
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [WIDTH-1:0]   r_top;
    logic [c_AW:0]      r_sp;

    logic [WIDTH-1:0]   w_din;
    logic               w_empty;
    logic               w_full;
    logic [c_AW:0]      w_sp_m1;
    logic [c_AW-1:0]    w_rd_idx;
    logic [c_AW-1:0]    w_wr_idx;
    logic               w_replace;
    logic               w_push;
    logic               w_pop;
    logic               w_peek;
    logic               w_load_top;

    assign w_din    = MtoS ? mem_data : alu_res;
    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == c_DEPTH);

    // sp-1 is only used when the stack is non-empty, so it lies in
    // 0..DEPTH-1 and the truncation to an address is exact.
    assign w_sp_m1  = r_sp - c_ONE;
    assign w_rd_idx = w_sp_m1[c_AW-1:0];
    assign w_wr_idx = r_sp[c_AW-1:0];

    // Operation decode. push&pop on a non-empty stack replaces the top;
    // on an empty stack it degrades to a plain push (never full when empty).
    // tos only counts when neither push nor pop is asserted.
    assign w_replace  = push & pop & ~w_empty;
    assign w_push     = push & ~w_replace & ~w_full;
    assign w_pop      = pop & ~push & ~w_empty;
    assign w_peek     = tos & ~push & ~pop & ~w_empty;
    assign w_load_top = w_replace | w_pop | w_peek;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp  <= '0;
            r_top <= '0;
        end else begin
            if (w_push) begin
                r_sp <= r_sp + c_ONE;
            end else if (w_pop) begin
                r_sp <= w_sp_m1;
            end
            // Reads the old top before a replace overwrites it.
            if (w_load_top) begin
                r_top <= r_mem[w_rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_replace) begin
            r_mem[w_rd_idx] <= w_din;
        end else if (w_push) begin
            r_mem[w_wr_idx] <= w_din;
        end
    end

`ifdef STACK_ERR_CHECK_EN
    logic w_ovf_evt;
    logic w_unf_evt;
    logic r_overflow;
    logic r_underflow;

    // A push&pop on an empty stack is a legal push, so it is not an underflow.
    assign w_ovf_evt = push & ~pop & w_full;
    assign w_unf_evt = ~push & (pop | tos) & w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign top_out = r_top;
    assign sp      = r_sp;
    assign empty   = w_empty;
    assign full    = w_full;

endmodule
`default_nettype wire

// File: tb/tb_operand_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_stack
// Brief    : Self-checking bench for operand_stack. Directed scenarios plus
//            randomized traffic, compared against a queue-based stack model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_stack;

    localparam int c_WIDTH = 8;
    localparam int c_DEPTH = 16;
    localparam int c_AW    = $clog2(c_DEPTH);

`ifdef STACK_ERR_CHECK_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  push;
    logic                  pop;
    logic                  tos;
    logic                  MtoS;
    logic [c_WIDTH-1:0]    mem_data;
    logic [c_WIDTH-1:0]    alu_res;
    logic [c_WIDTH-1:0]    top_out;
    logic [c_AW:0]         sp;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue is the stack (back = top).
    logic [c_WIDTH-1:0] m_q [$];
    logic [c_WIDTH-1:0] m_top;
    logic               m_ovf;
    logic               m_unf;

    operand_stack #(
        .WIDTH (c_WIDTH),
        .DEPTH (c_DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .tos       (tos),
        .MtoS      (MtoS),
        .mem_data  (mem_data),
        .alu_res   (alu_res),
        .top_out   (top_out),
        .sp        (sp),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".top_out"},   32'(top_out),   32'(m_top));
        chk({tag, ".sp"},        32'(sp),        32'(m_q.size()));
        chk({tag, ".empty"},     32'(empty),     32'(m_q.size() == 0));
        chk({tag, ".full"},      32'(full),      32'(m_q.size() == c_DEPTH));
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_top = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Stack semantics: push&pop replaces the top, tos only counts alone,
    // out-of-range operations are dropped and optionally flagged.
    task automatic model_step(input logic pu, input logic po, input logic to,
                              input logic [c_WIDTH-1:0] din);
        int n;
        n = m_q.size();
        if (pu && po && n > 0) begin
            m_top = m_q[n-1];
            m_q[n-1] = din;
        end else if (pu) begin
            if (n < c_DEPTH) m_q.push_back(din);
            else if (c_ERR_EN) m_ovf = 1'b1;
        end else if (po || to) begin
            if (n > 0) begin
                m_top = m_q[n-1];
                if (po) void'(m_q.pop_back());
            end else if (c_ERR_EN) begin
                m_unf = 1'b1;
            end
        end
    endtask

    // Drives one cycle of strobes, clocks it, updates the model and checks
    // 1 time unit after the edge.
    task automatic step(input string tag, input logic pu, input logic po, input logic to,
                        input logic ms, input logic [c_WIDTH-1:0] md,
                        input logic [c_WIDTH-1:0] ar);
        push = pu; pop = po; tos = to; MtoS = ms; mem_data = md; alu_res = ar;
        @(posedge clk);
        model_step(pu, po, to, ms ? md : ar);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        push = 1'b0; pop = 1'b0; tos = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r8;
        int         pw;
        rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0; MtoS = 1'b0;
        mem_data = '0; alu_res = '0;
        model_reset();
        @(negedge clk);
        do_reset("reset");

        // T1: async reset mid-run after 3 pushes
        step("t1.push0", 1, 0, 0, 1, 8'h41, 8'h00);
        step("t1.push1", 1, 0, 0, 0, 8'h00, 8'h42);
        step("t1.push2", 1, 0, 0, 1, 8'h43, 8'h00);
        do_reset("t1.rst");

        // T2: push from memory, push from ALU, pop twice
        step("t2.push_mem", 1, 0, 0, 1, 8'h11, 8'hEE);
        step("t2.push_alu", 1, 0, 0, 0, 8'hEE, 8'h22);
        step("t2.pop0",     0, 1, 0, 0, 8'h00, 8'h00);
        chk("t2.top22", 32'(top_out), 32'h22);
        step("t2.pop1",     0, 1, 0, 0, 8'h00, 8'h00);
        chk("t2.top11", 32'(top_out), 32'h11);
        chk("t2.empty", 32'(empty), 32'h1);

        // T3: tos twice leaves sp at 1
        step("t3.push", 1, 0, 0, 0, 8'h00, 8'h05);
        step("t3.tos0", 0, 0, 1, 0, 8'h00, 8'h00);
        step("t3.tos1", 0, 0, 1, 0, 8'h00, 8'h00);
        chk("t3.top05", 32'(top_out), 32'h05);
        do_reset("t3.rst");

        // T4: fill, push while full, pop reads 0x0F
        for (int i = 0; i < c_DEPTH; i++) step("t4.fill", 1, 0, 0, 0, 8'h00, 8'(i));
        chk("t4.full", 32'(full), 32'h1);
        step("t4.push_full", 1, 0, 0, 1, 8'hAA, 8'hAA);
        chk("t4.overflow", 32'(overflow), 32'(c_ERR_EN));
        step("t4.pop", 0, 1, 0, 0, 8'h00, 8'h00);
        chk("t4.top0f", 32'(top_out), 32'h0F);
        for (int i = 0; i < c_DEPTH - 1; i++) step("t4.drain", 0, 1, 0, 0, 8'h00, 8'h00);
        do_reset("t4.rst");

        // T5: pop and tos on empty are ignored; underflow sticks
        step("t5.pop_empty", 0, 1, 0, 0, 8'h00, 8'h00);
        step("t5.tos_empty", 0, 0, 1, 0, 8'h00, 8'h00);
        chk("t5.underflow", 32'(underflow), 32'(c_ERR_EN));
        step("t5.push", 1, 0, 0, 0, 8'h00, 8'h77);
        step("t5.pop",  0, 1, 0, 0, 8'h00, 8'h00);
        chk("t5.sticky", 32'(underflow), 32'(c_ERR_EN));
        do_reset("t5.rst");

        // T6: replace-top with push&pop, then pop the replacement
        step("t6.push1", 1, 0, 0, 0, 8'h00, 8'h01);
        step("t6.push2", 1, 0, 0, 0, 8'h00, 8'h02);
        step("t6.pushpop", 1, 1, 0, 1, 8'h33, 8'h00);
        chk("t6.top02", 32'(top_out), 32'h02);
        step("t6.pop", 0, 1, 0, 0, 8'h00, 8'h00);
        chk("t6.top33", 32'(top_out), 32'h33);
        // push&pop on empty acts as a push
        step("t6.pop_last", 0, 1, 0, 0, 8'h00, 8'h00);
        step("t6.pushpop_empty", 1, 1, 0, 0, 8'h00, 8'h9C);
        do_reset("t6.rst");

        // Randomized traffic, alternating fill-biased and drain-biased phases
        for (int ph = 0; ph < 8; ph++) begin
            pw = (ph % 2 == 0) ? 75 : 25;
            for (int k = 0; k < 60; k++) begin
                r8 = 8'($urandom);
                step("rnd",
                     ($urandom_range(0, 99) < pw),
                     ($urandom_range(0, 99) < (100 - pw)),
                     ($urandom_range(0, 99) < 30),
                     r8[0], 8'($urandom), 8'($urandom));
            end
            if (ph == 4) do_reset("rnd.rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
